// File: rtl/bsr_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bsr_pkg
// Description : Shared definitions for the BSR block scheduler and the sparse
//               systolic array: scheduler FSM states, default element/index
//               widths and block geometry.
// Revision    : 1.0 - initial release
// ============================================================================
package bsr_pkg;

    // Defaults shared with the sparse array
    localparam int BSR_DATA_WIDTH = 8;
    localparam int BSR_IDX_WIDTH  = 16;
    localparam int BSR_BLOCK_H    = 8;
    localparam int BSR_BLOCK_W    = 8;
    localparam int BLOCK_ELEMS    = BSR_BLOCK_H * BSR_BLOCK_W;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        PTR_LO  = 3'd1,
        PTR_HI  = 3'd2,
        ROW_CHK = 3'd3,
        FETCH   = 3'd4,
        WAIT    = 3'd5,
        ISSUE   = 3'd6,
        DONE    = 3'd7
    } state_t;

endpackage
`default_nettype wire

// File: rtl/bsr_block_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : bsr_block_scheduler
// Description : Walks a block-sparse-row weight matrix (row_ptr, col_idx and
//               8x8 INT8 payloads) and issues each non-zero block over a
//               valid/ready handshake tagged with its block row/column.
//               Empty rows cost no issue cycles.
// Ports       : clk, rst                 - clock, synchronous active-high reset
//               i_start, i_num_block_rows- launch a walk (sampled in IDLE only)
//               o_busy, o_done, o_err    - status; err is sticky until start
//               o_blocks_issued          - handshakes completed this walk
//               o_row_ptr_rd_en/addr, i_row_ptr_data - row_ptr read, 1-cycle
//               o_blk_rd_en/addr, i_col_idx_data, i_blk_data - block read
//               o_valid_out, i_ready, o_block_data, o_block_row,
//               o_block_col, o_row_last  - block output handshake
// Revision    : 1.0 - initial release
// ============================================================================
module bsr_block_scheduler #(
    parameter int DATA_WIDTH = bsr_pkg::BSR_DATA_WIDTH,
    parameter int BLOCK_H    = bsr_pkg::BSR_BLOCK_H,
    parameter int BLOCK_W    = bsr_pkg::BSR_BLOCK_W,
    parameter int PTR_WIDTH  = 32,
    parameter int IDX_WIDTH  = bsr_pkg::BSR_IDX_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_start,
    input  logic [IDX_WIDTH-1:0]  i_num_block_rows,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_err,
    output logic [31:0]           o_blocks_issued,
    output logic                  o_row_ptr_rd_en,
    output logic [IDX_WIDTH-1:0]  o_row_ptr_addr,
    input  logic [PTR_WIDTH-1:0]  i_row_ptr_data,
    output logic                  o_blk_rd_en,
    output logic [PTR_WIDTH-1:0]  o_blk_addr,
    input  logic [IDX_WIDTH-1:0]  i_col_idx_data,
    input  logic [DATA_WIDTH-1:0] i_blk_data [0:BLOCK_H*BLOCK_W-1],
    output logic                  o_valid_out,
    output logic [DATA_WIDTH-1:0] o_block_data [0:BLOCK_H*BLOCK_W-1],
    output logic [IDX_WIDTH-1:0]  o_block_row,
    output logic [IDX_WIDTH-1:0]  o_block_col,
    output logic                  o_row_last,
    input  logic                  i_ready
);
    import bsr_pkg::*;

    localparam int ELEMS = BLOCK_H * BLOCK_W;

    state_t                r_state;
    logic [IDX_WIDTH-1:0]  r_num;
    logic [IDX_WIDTH-1:0]  r_row;
    logic [PTR_WIDTH-1:0]  r_cur;
    logic [PTR_WIDTH-1:0]  r_end;
    logic                  r_first;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_err;
    logic [31:0]           r_blocks;
    logic                  r_row_ptr_rd_en;
    logic [IDX_WIDTH-1:0]  r_row_ptr_addr;
    logic                  r_blk_rd_en;
    logic [PTR_WIDTH-1:0]  r_blk_addr;
    logic                  r_valid;
    logic [DATA_WIDTH-1:0] r_block_data [0:ELEMS-1];
    logic [IDX_WIDTH-1:0]  r_block_row;
    logic [IDX_WIDTH-1:0]  r_block_col;
    logic                  r_row_last;

    logic [IDX_WIDTH-1:0]  w_row_inc;
    logic [IDX_WIDTH-1:0]  w_row_inc2;
    logic [PTR_WIDTH-1:0]  w_cur_inc;

    // r+1 is the row that becomes current after the row finishes; the next
    // row_ptr read for that row is at index (r+1)+1.
    assign w_row_inc  = r_row + IDX_WIDTH'(1);
    assign w_row_inc2 = r_row + IDX_WIDTH'(2);
    assign w_cur_inc  = r_cur + PTR_WIDTH'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= IDLE;
            r_num           <= '0;
            r_row           <= '0;
            r_cur           <= '0;
            r_end           <= '0;
            r_first         <= 1'b0;
            r_busy          <= 1'b0;
            r_done          <= 1'b0;
            r_err           <= 1'b0;
            r_blocks        <= '0;
            r_row_ptr_rd_en <= 1'b0;
            r_row_ptr_addr  <= '0;
            r_blk_rd_en     <= 1'b0;
            r_blk_addr      <= '0;
            r_valid         <= 1'b0;
            r_block_row     <= '0;
            r_block_col     <= '0;
            r_row_last      <= 1'b0;
            for (int k = 0; k < ELEMS; k++) begin
                r_block_data[k] <= '0;
            end
        end else begin
            // Read strobes and done are single-cycle; they are re-armed only
            // on the transition into the state that owns them.
            r_row_ptr_rd_en <= 1'b0;
            r_blk_rd_en     <= 1'b0;
            r_done          <= 1'b0;

            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_num    <= i_num_block_rows;
                        r_err    <= 1'b0;
                        r_blocks <= '0;
                        r_row    <= '0;
                        r_first  <= 1'b1;
                        if (i_num_block_rows == '0) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state         <= PTR_LO;
                            r_busy          <= 1'b1;
                            r_row_ptr_rd_en <= 1'b1;
                            r_row_ptr_addr  <= '0;
                        end
                    end
                end

                PTR_LO: begin
                    r_state         <= PTR_HI;
                    r_row_ptr_rd_en <= 1'b1;
                    r_row_ptr_addr  <= w_row_inc;
                end

                PTR_HI: begin
                    // row_ptr[0] arrives here; later rows inherit cur from
                    // the previous row's end.
                    if (r_first) begin
                        r_cur <= i_row_ptr_data;
                    end
                    r_first <= 1'b0;
                    r_state <= ROW_CHK;
                end

                ROW_CHK: begin
                    r_end <= i_row_ptr_data;
                    if (i_row_ptr_data > r_cur) begin
                        r_state     <= FETCH;
                        r_blk_rd_en <= 1'b1;
                        r_blk_addr  <= r_cur;
                    end else begin
                        // Empty row; a decreasing row_ptr is flagged and cur
                        // is left where it was.
                        if (i_row_ptr_data < r_cur) begin
                            r_err <= 1'b1;
                        end else begin
                            r_cur <= i_row_ptr_data;
                        end
                        r_row <= w_row_inc;
                        if (w_row_inc == r_num) begin
                            r_state <= DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_state         <= PTR_HI;
                            r_row_ptr_rd_en <= 1'b1;
                            r_row_ptr_addr  <= w_row_inc2;
                        end
                    end
                end

                FETCH: begin
                    r_state <= WAIT;
                end

                WAIT: begin
                    r_block_data <= i_blk_data;
                    r_block_col  <= i_col_idx_data;
                    r_block_row  <= r_row;
                    r_row_last   <= (w_cur_inc == r_end);
                    r_valid      <= 1'b1;
                    r_state      <= ISSUE;
                end

                ISSUE: begin
                    // Holding register and tags stay frozen until accepted.
                    if (i_ready) begin
                        r_valid  <= 1'b0;
                        r_blocks <= r_blocks + 32'd1;
                        r_cur    <= w_cur_inc;
                        if (w_cur_inc == r_end) begin
                            r_row <= w_row_inc;
                            if (w_row_inc == r_num) begin
                                r_state <= DONE;
                                r_busy  <= 1'b0;
                                r_done  <= 1'b1;
                            end else begin
                                r_state         <= PTR_HI;
                                r_row_ptr_rd_en <= 1'b1;
                                r_row_ptr_addr  <= w_row_inc2;
                            end
                        end else begin
                            r_state     <= FETCH;
                            r_blk_rd_en <= 1'b1;
                            r_blk_addr  <= w_cur_inc;
                        end
                    end
                end

                DONE: begin
                    r_state <= IDLE;
                end

                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_busy          = r_busy;
    assign o_done          = r_done;
    assign o_err           = r_err;
    assign o_blocks_issued = r_blocks;
    assign o_row_ptr_rd_en = r_row_ptr_rd_en;
    assign o_row_ptr_addr  = r_row_ptr_addr;
    assign o_blk_rd_en     = r_blk_rd_en;
    assign o_blk_addr      = r_blk_addr;
    assign o_valid_out     = r_valid;
    assign o_block_data    = r_block_data;
    assign o_block_row     = r_block_row;
    assign o_block_col     = r_block_col;
    assign o_row_last      = r_row_last;

endmodule
`default_nettype wire
